// File: rtl/cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// cacheline_adaptor
//
// Bridges a cache's line-wide physical-memory port to a narrow burst memory.
// Each line fill becomes a BEATS-long read burst. Each line writeback becomes
// a BEATS-long write burst. The cache sees a single-cycle resp_o once the
// burst has completed.
//
// Ports
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   address_i  in   32       cache-side line address
//   read_i     in   1        line fill request, held until resp_o
//   write_i    in   1        line writeback request, held until resp_o
//   line_i     in   LINE_W   line to write back
//   line_o     out  LINE_W   filled line (or last written line)
//   resp_o     out  1        one-cycle completion pulse to the cache
//   address_o  out  32       line-aligned burst address
//   read_o     out  1        read burst request to memory
//   write_o    out  1        write burst request to memory
//   burst_o    out  BURST_W  write beat data
//   burst_i    in   BURST_W  read beat data
//   resp_i     in   1        memory beat strobe, one beat per high cycle
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; write wins over read
// RD    | read burst; capture burst_i into line_q on each resp_i
// WR    | write burst; drive line_q beat cnt on burst_o
// DONE  | resp_o pulse; requests ignored, back to IDLE next cycle
// -----------------------------------------------------------------------------
module cacheline_adaptor #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    output logic               resp_o,

    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    output logic [BURST_W-1:0] burst_o,
    input  logic [BURST_W-1:0] burst_i,
    input  logic               resp_i
);

    // BEATS must be a power of two. CNT_W is held at 1 or more so the
    // counter stays legal in the degenerate single-beat case.
    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_W / 8);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [31:0]      ADDR_MASK = ~((32'd1 << OFF_W) - 32'd1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_inc;
    logic [LINE_W-1:0]  line_q;
    logic [31:0]        addr_q;
    logic [31:0]        addr_aligned;
    logic               in_burst;
    logic               last_beat;

    assign addr_aligned = address_i & ADDR_MASK;
    assign in_burst     = (state_q == RD) || (state_q == WR);
    assign last_beat    = (cnt_q == LAST_BEAT);

    // The counter is cleared explicitly on the last beat so that it
    // also wraps correctly when BEATS is 1.
    assign cnt_inc      = last_beat ? '0 : cnt_q + CNT_W'(1);

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (write_i) begin
                    state_d = WR;
                end else if (read_i) begin
                    state_d = RD;
                end
            end
            RD, WR: begin
                if (resp_i && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath: beat counter, line buffer, latched address
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            line_q <= '0;
            addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (write_i) begin
                        line_q <= line_i;
                        addr_q <= addr_aligned;
                        cnt_q  <= '0;
                    end else if (read_i) begin
                        addr_q <= addr_aligned;
                        cnt_q  <= '0;
                    end
                end
                RD: begin
                    if (resp_i) begin
                        line_q[BURST_W*cnt_q +: BURST_W] <= burst_i;
                        cnt_q <= cnt_inc;
                    end
                end
                WR: begin
                    if (resp_i) begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Outputs: pure decodes of registered state
    // ---------------------------------------------------------------
    assign read_o    = (state_q == RD);
    assign write_o   = (state_q == WR);
    assign resp_o    = (state_q == DONE);
    assign address_o = addr_q;
    assign line_o    = line_q;
    assign burst_o   = (state_q == WR) ? line_q[BURST_W*cnt_q +: BURST_W]
                                       : '0;

    // in_burst groups the two burst states for readability of the decode.
    logic unused_ok;
    assign unused_ok = in_burst;

endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Bridges the cache's 256-bit line-wide physical-memory port (`pmem_address`, `pmem_rdata`, `pmem_wdata`) to a 64-bit burst memory.

- Converts each line fill into a 4-beat read burst and each line writeback into a 4-beat write burst.
- Returns a single-cycle response to the cache when the burst completes.
- Sits directly downstream of the cache datapath and controller.

## Interface
- `LINE_W`, 256, cache line width in bits.
- `BURST_W`, 64, memory beat width. `LINE_W/BURST_W` (= 4, BEATS) must be an integer power of two.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `address_i`  in  32  cache-side line address.
- `read_i`  in  1  cache requests a line fill; held until `resp_o`.
- `write_i`  in  1  cache requests a line writeback; held until `resp_o`.
- `line_i`  in  LINE_W  line to write back.
- `line_o`  out  LINE_W  filled line, assembled from the read burst.
- `resp_o`  out  1  one-cycle completion pulse to the cache.
- `address_o`  out  32  line-aligned burst address.
- `read_o`  out  1  read burst request to memory.
- `write_o`  out  1  write burst request to memory.
- `burst_o`  out  BURST_W  write beat data.
- `burst_i`  in  BURST_W  read beat data.
- `resp_i`  in  1  memory beat strobe; one beat transferred per cycle it is high during a burst.

## Operation
- States: IDLE, RD, WR, DONE. Beat counter `cnt` is log2(BEATS) bits. Registered `line_q` and `addr_q`.
- **IDLE**
  - `write_i`=1: latch `line_q`<=`line_i` and `addr_q`<=`{address_i[31:5],5'b0}`; set `cnt`<=0; go to WR.
  - Else if `read_i`=1: latch `addr_q`; set `cnt`<=0; go to RD.
  - Write has priority when both are high; the read is served only after its own later request.
- **RD**
  - `read_o`=1.
  - On each cycle with `resp_i`=1: `line_q[BURST_W*cnt +: BURST_W]`<=`burst_i` and `cnt`<=`cnt`+1.
  - When `cnt`=BEATS-1 and `resp_i`=1: go to DONE; `cnt` wraps to 0.
  - `resp_i`=0 cycles are stalls; no state change.
- **WR**
  - `write_o`=1 and `burst_o`=`line_q[BURST_W*cnt +: BURST_W]`.
  - Advance and exit exactly as in RD.
- **DONE**
  - `resp_o`=1 for exactly one cycle, then IDLE unconditionally.
  - `read_i`/`write_i` are ignored in DONE. A request still high in the following IDLE cycle starts a new transaction.
- Beat order is fixed: beat 0 carries line bits [63:0], beat 3 carries [255:192]. No wrap-around or critical-word-first ordering.
- `address_o`=`addr_q` at all times; it is constant for the whole burst.
- `line_o`=`line_q`.
  - After a read, it is valid from DONE onward and held until the next read burst overwrites it.
  - A write leaves `line_q` holding the written line, so `line_o` then equals `line_i` as latched.
- `burst_o`=0 outside WR.
- `resp_i` outside RD/WR is ignored.
- Reset (async, any state, including mid-burst):
  - State goes to IDLE; `cnt`, `line_q` and `addr_q` clear to 0.
  - All outputs go to 0: `resp_o`, `read_o`, `write_o`, `burst_o`, `address_o`, `line_o`.
  - An abandoned burst is not resumed.

## Timing
- Request sampled in IDLE at edge 0. `read_o`/`write_o` are high from cycle 1 until the edge that accepts the last beat.
- With no stalls, beats are accepted at edges 1–4, `resp_o` is high in cycle 5, and the block is back in IDLE in cycle 6.
  - Minimum request-to-`resp_o` latency is 5 cycles.
  - Each stall cycle adds 1 cycle.
- Outputs are registered-state decodes; there is no combinational path from `read_i`/`write_i`/`burst_i` to any output.
- Back-to-back transactions: a new request can be accepted in the first IDLE cycle after DONE, giving 6 cycles per unstalled transaction.

## Test plan
- **Reset:** assert `rst_n`=0 mid-RD after 2 beats -> all outputs 0 immediately. After release, `read_i`=1 restarts at beat 0, and `address_o` carries the newly latched address.
- **Unstalled read:**
  - Stimulus: `address_i`=0x1234_5678; beats 0x1111_1111_1111_1111, 0x2222…, 0x3333…, 0x4444… with `resp_i` high 4 cycles.
  - Required: `address_o`=0x1234_5660, `read_o` high 4 cycles, `resp_o` in cycle 5, `line_o`=0x4444…_3333…_2222…_1111….
- **Stalled read:** `resp_i` pattern 1,0,0,1,1,0,1 -> exactly 4 beats captured in order, `resp_o` 1 cycle after the 4th beat, `read_o` stays high through the stalls.
- **Write burst:**
  - Stimulus: `line_i`=0xDDDD…_CCCC…_BBBB…_AAAA… and `address_i`=0x8000_00FF, with `line_i` changed to 0 after the request cycle.
  - Required: `address_o`=0x8000_00E0; `burst_o`=AAAA…, BBBB…, CCCC…, DDDD… on successive accepted beats; `write_o` drops after beat 3; single `resp_o` pulse.
- **Simultaneous request:** `read_i`=`write_i`=1 in IDLE -> WR burst first; after `resp_o`, with `read_i` still 1 and `write_i` 0, an RD burst follows on the next IDLE cycle.
- **Idle noise:** `resp_i`=1 and `burst_i` toggling for 10 cycles in IDLE -> no `resp_o`, `line_o` unchanged, `cnt` stays 0.
